// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the accelerator SRAM port arbiter: requester map,
// default geometry and the buffer base-address layout helpers.
package sram_port_arbiter_pkg;

  localparam int NREQ = 7;
  localparam int AW   = 14;
  localparam int DW   = 32;

  localparam int REQ_WHT_WR  = 0;
  localparam int REQ_IFM_WR  = 1;
  localparam int REQ_WHT_RD  = 2;
  localparam int REQ_IFM_RD  = 3;
  localparam int REQ_PSUM_WR = 4;
  localparam int REQ_PSUM_RD = 5;
  localparam int REQ_OUT_RD  = 6;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam logic [AW-1:0] WHT_BASE = 14'h0000;

  // Buffers are packed back to back: weights, then IFM, then outputs.
  function automatic logic [AW-1:0] ifm_base(input logic [AW-1:0] wht_words);
    return WHT_BASE + wht_words;
  endfunction

  function automatic logic [AW-1:0] out_base(input logic [AW-1:0] wht_words,
                                             input logic [AW-1:0] ifm_words);
    return ifm_base(wht_words) + ifm_words;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority (index 0 first) or round robin
// starting at ptr; reports the one-hot winner and the pointer after it.
module rr_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int N  = 7,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          rr_en,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr,
  output logic          found
);

  arb_mode_e     mode_s;
  logic [PW:0]   start_s;
  logic [PW:0]   cand_s;
  logic [PW-1:0] idx_s;
  logic          hit_s;

  assign mode_s = rr_en ? ARB_RR : ARB_FIXED;

  // Scan N positions from the start point, wrapping, and keep the first hit.
  always_comb begin
    grant    = {N{1'b0}};
    next_ptr = ptr;
    found    = 1'b0;
    cand_s   = {(PW+1){1'b0}};
    idx_s    = {PW{1'b0}};
    hit_s    = 1'b0;
    start_s  = (mode_s == ARB_RR) ? {1'b0, ptr} : {(PW+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      cand_s       = start_s + (PW+1)'(k);
      idx_s        = (cand_s >= (PW+1)'(N)) ? PW'(cand_s - (PW+1)'(N)) : PW'(cand_s);
      hit_s        = ~found & req[idx_s];
      grant[idx_s] = grant[idx_s] | hit_s;
      next_ptr     = hit_s ? ((idx_s == PW'(N - 1)) ? {PW{1'b0}} : idx_s + PW'(1))
                           : next_ptr;
      found        = found | hit_s;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single-port accelerator SRAM among NREQ requesters with base
// relocation, a registered command stage and tagged in-order read return.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NREQ   = sram_port_arbiter_pkg::NREQ,
  parameter int AW     = sram_port_arbiter_pkg::AW,
  parameter int DW     = sram_port_arbiter_pkg::DW,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_en,
  input  logic                 rr_en,
  input  logic [NREQ*AW-1:0]   cfg_base,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*4-1:0]    req_wem,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [3:0]           sram_wem,
  output logic [AW-1:0]        sram_addr,
  output logic [DW-1:0]        sram_din,
  input  logic [DW-1:0]        sram_dout,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic [3:0]           rsp_wem
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] cand_s;
  logic [NREQ-1:0] grant_s;
  logic [IDXW-1:0] next_ptr_s;
  logic [IDXW-1:0] ptr_r;
  logic            any_s;

  logic [IDXW-1:0] win_idx_s;
  logic            sel_we_s;
  logic [3:0]      sel_wem_s;
  logic [AW-1:0]   sel_addr_s;
  logic [AW-1:0]   sel_base_s;
  logic [DW-1:0]   sel_wdata_s;

  logic            tag_vld_r [0:RD_LAT];
  logic [IDXW-1:0] tag_idx_r [0:RD_LAT];
  logic [3:0]      tag_wem_r [0:RD_LAT];

  // Reset also blocks grants so nothing is accepted while the block is held.
  assign cand_s = req_valid & {NREQ{arb_en & ~rst}};

  rr_arbiter #(
    .N  (NREQ),
    .PW (IDXW)
  ) u_rr_arbiter (
    .req      (cand_s),
    .rr_en    (rr_en),
    .ptr      (ptr_r),
    .grant    (grant_s),
    .next_ptr (next_ptr_s),
    .found    (any_s)
  );

  assign req_ready = grant_s;

  // One-hot AND-OR mux of the winning requester's command fields.
  always_comb begin
    win_idx_s   = {IDXW{1'b0}};
    sel_we_s    = 1'b0;
    sel_wem_s   = 4'h0;
    sel_addr_s  = {AW{1'b0}};
    sel_base_s  = {AW{1'b0}};
    sel_wdata_s = {DW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      win_idx_s   = win_idx_s   | (IDXW'(i) & {IDXW{grant_s[i]}});
      sel_we_s    = sel_we_s    | (req_we[i] & grant_s[i]);
      sel_wem_s   = sel_wem_s   | (req_wem[i*4 +: 4] & {4{grant_s[i]}});
      sel_addr_s  = sel_addr_s  | (req_addr[i*AW +: AW] & {AW{grant_s[i]}});
      sel_base_s  = sel_base_s  | (cfg_base[i*AW +: AW] & {AW{grant_s[i]}});
      sel_wdata_s = sel_wdata_s | (req_wdata[i*DW +: DW] & {DW{grant_s[i]}});
    end
  end

  // Command register and round-robin pointer; idle cycles only drop cs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r     <= {IDXW{1'b0}};
      sram_cs   <= 1'b0;
      sram_we   <= 1'b0;
      sram_wem  <= 4'h0;
      sram_addr <= {AW{1'b0}};
      sram_din  <= {DW{1'b0}};
    end else if (any_s) begin
      sram_cs   <= 1'b1;
      sram_we   <= sel_we_s;
      sram_wem  <= sel_wem_s;
      sram_addr <= sel_addr_s + sel_base_s;
      if (sel_we_s) begin
        sram_din <= sel_wdata_s;
      end
      ptr_r <= rr_en ? next_ptr_s : ptr_r;
    end else begin
      sram_cs <= 1'b0;
    end
  end

  // Read tags travel alongside the SRAM latency so responses stay in grant order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j <= RD_LAT; j++) begin
        tag_vld_r[j] <= 1'b0;
        tag_idx_r[j] <= {IDXW{1'b0}};
        tag_wem_r[j] <= 4'h0;
      end
    end else begin
      tag_vld_r[0] <= any_s & ~sel_we_s;
      tag_idx_r[0] <= win_idx_s;
      tag_wem_r[0] <= sel_wem_s;
      for (int j = 1; j <= RD_LAT; j++) begin
        tag_vld_r[j] <= tag_vld_r[j-1];
        tag_idx_r[j] <= tag_idx_r[j-1];
        tag_wem_r[j] <= tag_wem_r[j-1];
      end
    end
  end

  // Response register: the last tag stage lines up with valid sram_dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= {NREQ{1'b0}};
      rsp_data  <= {DW{1'b0}};
      rsp_wem   <= 4'h0;
    end else if (tag_vld_r[RD_LAT]) begin
      rsp_valid <= NREQ'(1'b1) << tag_idx_r[RD_LAT];
      rsp_data  <= sram_dout;
      rsp_wem   <= tag_wem_r[RD_LAT];
    end else begin
      rsp_valid <= {NREQ{1'b0}};
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised and directed bench for sram_port_arbiter against a transaction
// level model: arbitration by scan, golden memory, and a response queue.
module tb_sram_port_arbiter;

  localparam int NREQ   = 7;
  localparam int AW     = 14;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, arb_en, rr_en;
  logic [NREQ*AW-1:0]  cfg_base, req_addr;
  logic [NREQ-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [NREQ*4-1:0]   req_wem;
  logic [NREQ*DW-1:0]  req_wdata;
  logic                sram_cs, sram_we;
  logic [3:0]          sram_wem, rsp_wem;
  logic [AW-1:0]       sram_addr;
  logic [DW-1:0]       sram_din, sram_dout, rsp_data;

  sram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .rr_en(rr_en), .cfg_base(cfg_base),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wem(req_wem), .req_wdata(req_wdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_wem(sram_wem),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_wem(rsp_wem)
  );

  // SRAM behavioural model with byte-masked writes and RD_LAT read latency.
  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] rd_pipe [0:RD_LAT-1];
  assign sram_dout = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (sram_cs && sram_we)
      for (int b = 0; b < 4; b++)
        if (sram_wem[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
    if (sram_cs && !sram_we) rd_pipe[0] <= mem[sram_addr];
    for (int j = 1; j < RD_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
  end

  typedef struct {
    int            due;
    int            idx;
    logic [3:0]    wem;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          rspq[$];
  logic [DW-1:0] gold [0:DEPTH-1];
  int            n_cmp = 0, n_err = 0, cyc = 0, ptr = 0, rsp_seen = 0, seen0;
  logic          exp_cs, exp_we;
  logic [3:0]    exp_wem;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din, last_rsp_data;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_winner();
    int start = rr_en ? ptr : 0;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  // One clock: check grant before the edge, advance the model, check after.
  task automatic run_cycle();
    int win, a;
    logic [DW-1:0] word;
    rsp_t r;
    #1;
    win = (rst || !arb_en) ? -1 : model_winner();
    check_eq("req_ready", req_ready, (win < 0) ? 64'd0 : (64'd1 << win));
    @(posedge clk);
    cyc++;
    if (rst) begin
      ptr = 0; exp_cs = 1'b0; exp_we = 1'b0; exp_wem = 4'h0;
      exp_addr = '0; exp_din = '0; rspq.delete();
    end else if (win >= 0) begin
      a = (int'(req_addr[win*AW +: AW]) + int'(cfg_base[win*AW +: AW])) % DEPTH;
      exp_cs = 1'b1; exp_we = req_we[win]; exp_wem = req_wem[win*4 +: 4];
      exp_addr = a[AW-1:0];
      if (req_we[win]) begin
        exp_din = req_wdata[win*DW +: DW];
        word = gold[a];
        for (int b = 0; b < 4; b++)
          if (exp_wem[b]) word[8*b +: 8] = exp_din[8*b +: 8];
        gold[a] = word;
      end else begin
        r.due = cyc + RD_LAT + 1; r.idx = win; r.wem = exp_wem; r.data = gold[a];
        rspq.push_back(r);
      end
      if (rr_en) ptr = (win + 1) % NREQ;
    end else begin
      exp_cs = 1'b0;
    end
    #1;
    check_eq("sram_cs", sram_cs, exp_cs);
    check_eq("sram_we", sram_we, exp_we);
    check_eq("sram_wem", sram_wem, exp_wem);
    check_eq("sram_addr", sram_addr, exp_addr);
    check_eq("sram_din", sram_din, exp_din);
    if (rspq.size() > 0 && rspq[0].due == cyc) begin
      r = rspq.pop_front();
      check_eq("rsp_valid", rsp_valid, 64'd1 << r.idx);
      check_eq("rsp_data", rsp_data, r.data);
      check_eq("rsp_wem", rsp_wem, r.wem);
    end else begin
      check_eq("rsp_idle", rsp_valid, 64'd0);
    end
    if (rsp_valid != '0) begin
      rsp_seen++;
      last_rsp_data = rsp_data;
    end
    @(negedge clk);
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_we    = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr,
                         input logic [3:0] wem, input logic [DW-1:0] wd);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = addr;
    req_wem[i*4 +: 4]     = wem;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic set_base(input int i, input logic [AW-1:0] base);
    cfg_base[i*AW +: AW] = base;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      gold[i] = '0;
    end
    for (int j = 0; j < RD_LAT; j++) rd_pipe[j] = '0;
    rst = 1'b1; arb_en = 1'b1; rr_en = 1'b0;
    cfg_base = '0; req_addr = '0; req_wem = '0; req_wdata = '0;
    idle_all();
    exp_cs = 1'b0; exp_we = 1'b0; exp_wem = 4'h0; exp_addr = '0; exp_din = '0;
    last_rsp_data = '0;

    set_req(2, 1'b0, 14'h0001, 4'hF, 32'h0);
    repeat (2) run_cycle();
    check_eq("reset_rsp", rsp_valid, 64'd0);
    rst = 1'b0;

    // Fixed priority with requesters 2 and 4: 2 always wins.
    set_req(4, 1'b0, 14'h0002, 4'hF, 32'h0);
    repeat (6) begin
      #1 check_eq("fixed_prio", req_ready, 64'h04);
      run_cycle();
    end
    idle_all();
    repeat (3) run_cycle();

    // Round robin from a freshly reset pointer.
    rst = 1'b1; run_cycle(); rst = 1'b0;
    rr_en = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), 4'hF, 32'h0);
    for (int k = 0; k < 14; k++) begin
      #1 check_eq("rr_order", req_ready, 64'd1 << (k % NREQ));
      run_cycle();
    end
    idle_all();
    repeat (3) run_cycle();
    rr_en = 1'b0;

    // Relocation and address wrap.
    set_base(4, 14'h1F80);
    set_req(4, 1'b1, 14'h0005, 4'hF, 32'hDEADBEEF);
    run_cycle();
    check_eq("reloc_addr", sram_addr, 14'h1F85);
    check_eq("reloc_din", sram_din, 32'hDEADBEEF);
    check_eq("reloc_we", sram_we, 1'b1);
    idle_all();
    set_base(5, 14'h3FFF);
    set_req(5, 1'b0, 14'h0002, 4'hF, 32'h0);
    run_cycle();
    check_eq("wrap_addr", sram_addr, 14'h0001);
    idle_all();
    repeat (3) run_cycle();

    // Back-to-back reads from requesters 2 and 3.
    set_base(2, 14'h0000); set_base(3, 14'h0000);
    set_req(2, 1'b0, 14'h1F85, 4'h2, 32'h0);
    run_cycle();
    idle_all();
    set_req(3, 1'b0, 14'h0001, 4'hF, 32'h0);
    run_cycle();
    idle_all();
    run_cycle();
    check_eq("rd2_valid", rsp_valid, 64'h04);
    check_eq("rd2_wem", rsp_wem, 4'h2);
    check_eq("rd2_data", rsp_data, 32'hDEADBEEF);
    run_cycle();
    check_eq("rd3_valid", rsp_valid, 64'h08);

    // Write then read of the same word.
    set_base(4, 14'h0000); set_base(5, 14'h0000);
    set_req(4, 1'b1, 14'd10, 4'hF, 32'h12345678);
    run_cycle();
    idle_all();
    set_req(5, 1'b0, 14'd10, 4'hF, 32'h0);
    run_cycle();
    idle_all();
    repeat (3) run_cycle();
    check_eq("wr_rd_data", last_rsp_data, 32'h12345678);

    // Reset right after a read accept drops the response and clears the pointer.
    rr_en = 1'b1;
    set_req(3, 1'b0, 14'd10, 4'hF, 32'h0);
    run_cycle();
    idle_all();
    seen0 = rsp_seen;
    rst = 1'b1; run_cycle(); rst = 1'b0;
    repeat (4) run_cycle();
    check_eq("rst_drop_rsp", rsp_seen - seen0, 64'd0);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), 4'hF, 32'h0);
    #1 check_eq("rst_ptr", req_ready, 64'd1);

    // arb_en low with everything pending.
    arb_en = 1'b0;
    repeat (3) begin
      run_cycle();
      check_eq("arb_off_cs", sram_cs, 1'b0);
    end
    arb_en = 1'b1;
    idle_all();
    repeat (3) run_cycle();

    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0)
        for (int i = 0; i < NREQ; i++)
          case ($urandom_range(0, 2))
            0:       set_base(i, 14'h0000);
            1:       set_base(i, 14'h3FF8);
            default: set_base(i, AW'($urandom));
          endcase
      rst    = ($urandom_range(0, 99) == 0);
      arb_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) rr_en = ~rr_en;
      idle_all();
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)),
                  4'($urandom), $urandom);
      run_cycle();
    end
    rst = 1'b0;
    idle_all();
    repeat (RD_LAT + 4) run_cycle();
    check_eq("rspq_drained", rspq.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-port 32-bit accelerator SRAM (sram_top) among NREQ requesters: weight/IFM load writes, weight/IFM fetch reads, psum write/read-back and output drain.
- Replaces the top-level priority if-chain with a parameterised arbiter. Adds per-requester base-address relocation and tagged, in-order read-response return.
- Sits between ctrl / serialiser blocks and sram_top.

Parameters:
- NREQ, 7, number of requester ports; index 0 has the highest fixed priority.
- AW, 14, SRAM word-address width.
- DW, 32, SRAM data width.
- RD_LAT, 1, SRAM read latency in cycles from the sampling edge to valid dout (1..3).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- arb_en  input  1  1 = grants allowed; 0 = no new grants, in-flight reads still complete
- rr_en  input  1  1 = round-robin arbitration, 0 = fixed priority
- cfg_base  input  NREQ*AW  per-requester word base address, slice i = [AW*(i+1)-1:AW*i]
- req_valid  input  NREQ  request valid
- req_ready  output  NREQ  request accepted this cycle
- req_we  input  NREQ  1 = write, 0 = read
- req_addr  input  NREQ*AW  relative word address
- req_wem  input  NREQ*4  write byte mask / read byte-lane select
- req_wdata  input  NREQ*DW  write data
- sram_cs  output  1  SRAM chip select
- sram_we  output  1  SRAM write enable
- sram_wem  output  4  SRAM byte mask
- sram_addr  output  AW  SRAM word address
- sram_din  output  DW  SRAM write data
- sram_dout  input  DW  SRAM read data
- rsp_valid  output  NREQ  one-hot read-response strobe
- rsp_data  output  DW  read word
- rsp_wem  output  4  wem of the originating read, for byte-lane muxing

Behaviour:
- Reset: all outputs 0, RR pointer 0, response tag pipeline cleared. Reads in flight are dropped; no rsp_valid is issued for them.
- Arbitration (combinational each cycle):
  - Candidates = req_valid & {NREQ{arb_en}}.
  - rr_en=0: lowest set index wins.
  - rr_en=1: first set index at or above the pointer wins, wrapping modulo NREQ. After each grant the pointer moves to winner+1, wrapping NREQ-1 -> 0.
  - Pointer does not move on idle cycles.
  - rr_en may change on any cycle; the pointer is kept.
- req_ready: one-hot of the winner, 0 when there are no candidates. Accept = req_valid[i] & req_ready[i]. At most one accept per cycle; no stall beyond arbitration.
- Command register: on the accepting edge, load the SRAM outputs:
  - sram_cs=1
  - sram_we=req_we[i]
  - sram_wem=req_wem[i]
  - sram_addr=(req_addr[i]+cfg_base[i]) mod 2^AW, wrap silently
  - sram_din=req_wdata[i] on writes only; holds on reads
- Idle cycle (no accept): sram_cs=0; sram_we, sram_wem, sram_addr and sram_din hold their values.
- Command latency: request accepted at edge E0 -> SRAM command presented during cycle E0..E1 -> SRAM samples at E1.
- Read response:
  - Tag {valid, index, wem} enters a shift pipeline of depth RD_LAT+1 on each accepted read.
  - rsp_valid[index]=1 for exactly one cycle, RD_LAT+1 cycles after the accepting edge, with rsp_data=sram_dout and rsp_wem=tag wem.
  - Responses are in grant order; back-to-back reads give back-to-back responses.
  - rsp_data is undefined when rsp_valid=0; the bench must not check it then.
- Ordering: a write and a following read to the same address are issued to the SRAM in grant order, so the read returns the new data.
- arb_en falling mid-stream: the in-progress accept in that cycle is suppressed; reads already accepted still return.
- rst asserted mid-operation: the next cycle matches reset state exactly.

Decomposition:
- Shared package: requester index localparams (REQ_WHT_WR=0, REQ_IFM_WR=1, REQ_WHT_RD=2, REQ_IFM_RD=3, REQ_PSUM_WR=4, REQ_PSUM_RD=5, REQ_OUT_RD=6), NREQ, AW, and the IFM/WHT/OUT base-address formulas.
- Sub-module rr_arbiter: request vector, rr_en and pointer in; one-hot grant and next pointer out. Combinational, reused by future DMA blocks.

Test Plan:
- Fixed priority: rr_en=0, req_valid=7'b0010100 held -> req_ready=7'b0000100 every cycle; requester 4 starves.
- Round robin: rr_en=1, all 7 valid for 14 cycles -> grant order 0,1,2,3,4,5,6,0,...,6, one per cycle.
- Relocation and write: req 4 writes addr 0x0005, base 0x1F80, wdata 0xDEADBEEF, wem 4'hF -> next cycle sram_cs=1, we=1, addr=0x1F85, din=0xDEADBEEF. Address wrap: base 0x3FFF + addr 2 -> 0x0001.
- Read return: req 2 reads with wem 4'h2, then req 3 reads back-to-back, RD_LAT=1 -> rsp_valid=0x04 at accept+2, rsp_wem=2, then rsp_valid=0x08 at accept+3, each with the matching data.
- Write-then-read: write 0x12345678 to addr 10, then read addr 10 -> rsp_data=0x12345678.
- Reset and arb_en: rst pulsed the cycle after a read is accepted -> no rsp_valid, all outputs 0, pointer 0. arb_en=0 with requests pending -> req_ready=0 and sram_cs=0.
